// File: rtl/soc_system_sph_led_pio_pkg.sv
// LED PIO shared definitions: register offsets and STATUS bit layout.
// Used by soc_system_sph_led_blink_pio and its testbench.
package soc_system_sph_led_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/soc_system_sph_led_blink_timebase.sv
// Blink timebase: each half-period lasts period+1 cycles; period==0 holds phase 0.
// A period write restarts the count from phase 0.
module soc_system_sph_led_blink_timebase #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  period_wr,
  output logic                  blink_phase
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  // Next count/phase: restart on period write, idle at zero period, else count and wrap.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_wr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (period == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timebase state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/soc_system_sph_led_blink_pio.sv
// Avalon-MM LED output PIO with per-bit blink mask and programmable timebase.
// Optional SPH_LED_PIO_SETCLR_EN adds atomic OUTSET (4) / OUTCLEAR (5) ports.
module soc_system_sph_led_blink_pio
  import soc_system_sph_led_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int RESET_VALUE = 15,
  parameter int PRESCALE_W  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [31:0]           rd_q, rd_d;
  logic                  wr;
  logic                  period_wr;
  logic                  blink_phase;
  logic [WIDTH-1:0]      wd_w;
  logic [WIDTH-1:0]      dark;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign period_wr = wr && (address == ADDR_PERIOD);
  assign wd_w      = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  soc_system_sph_led_blink_timebase #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tb (
    .clk        (clk),
    .reset      (reset),
    .period     (period_q),
    .period_wr  (period_wr),
    .blink_phase(blink_phase)
  );

  // Register write decode; RO and reserved offsets fall through unchanged.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d   = wd_w;
        ADDR_MASK:   mask_d   = wd_w;
        ADDR_PERIOD: period_d = writedata[PRESCALE_W-1:0];
`ifdef SPH_LED_PIO_SETCLR_EN
        ADDR_OUTSET: data_d   = data_q | wd_w;
        ADDR_OUTCLR: data_d   = data_q & ~wd_w;
`endif
        default: ;
      endcase
    end
  end

  // Read mux: addressed register, zero-extended; write-only and reserved read 0.
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:   rd_d = 32'(data_q);
      ADDR_MASK:   rd_d = 32'(mask_q);
      ADDR_PERIOD: rd_d = 32'(period_q);
      ADDR_STATUS: rd_d[STATUS_PHASE_BIT] = blink_phase;
      default: ;
    endcase
  end

  // Register file and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RST_DATA;
      mask_q   <= '0;
      period_q <= '0;
      rd_q     <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      rd_q     <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign dark     = mask_q & {WIDTH{blink_phase}};
  assign out_port = data_q & ~dark;

endmodule
